muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit producing HI/LO. Generalises the CPU's separate mult/div blocks, HI/LO muxes and HI/LO registers into one block.
- Adds signed/unsigned modes, a start/busy/done handshake and direct HI/LO writes (mthi/mtlo).
- Sits beside the ALU. The control FSM issues start and waits on done. HI/LO feed the MemToReg mux.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers,
// start/busy/done handshake and direct HI/LO writes.
//
// state | meaning
// IDLE  | accept start, honour hi_we/lo_we, flag divide-by-zero
// RUN   | one multiplier/quotient bit per cycle, counter counts down
// FIN   | sign-correct and write HI/LO, pulse done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_work_q, lo_work_q, opnd_q;
  logic [WIDTH-1:0]   hi_work_d, lo_work_d;
  logic               is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dz_q, dz_pend_q;

  // Operand preparation at start
  op_e              op_in;
  logic             in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in     = op_e'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign a_neg     = in_signed && a[WIDTH-1];
  assign b_neg     = in_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One WIDTH+1-bit adder serves both algorithms; the carry out of the
  // subtract is the restoring-division "no borrow" decision.
  logic [WIDTH:0]   add_a, add_b;
  logic [WIDTH+1:0] sum;

  always_comb begin
    add_a = is_div_q ? {hi_work_q, lo_work_q[WIDTH-1]} : {1'b0, hi_work_q};
    add_b = {1'b0, opnd_q};
    sum   = {1'b0, add_a} + {1'b0, (is_div_q ? ~add_b : add_b)}
          + {{(WIDTH+1){1'b0}}, is_div_q};
    hi_work_d = hi_work_q;
    lo_work_d = lo_work_q;
    if (is_div_q) begin
      hi_work_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      lo_work_d = {lo_work_q[WIDTH-2:0], sum[WIDTH+1]};
    end else if (lo_work_q[0]) begin
      {hi_work_d, lo_work_d} = {sum[WIDTH:0], lo_work_q[WIDTH-1:1]};
    end else begin
      {hi_work_d, lo_work_d} = {1'b0, hi_work_q, lo_work_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

  always_comb begin
    prod     = {hi_work_q, lo_work_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -lo_work_q : lo_work_q;
    rem_fix  = neg_rem_q ? -hi_work_q : hi_work_q;
    hi_res   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_work_q <= '0;
      lo_work_q <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dz_pend_q) begin
            done_q <= 1'b1;
            dz_q   <= 1'b1;
          end
          if (hi_we) hi_q <= hi_wdata;
          if (lo_we) lo_q <= lo_wdata;
          if (start) begin
            if (in_div && (b == '0)) begin
              dz_pend_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              cnt_q     <= CNT_W'(WIDTH);
              is_div_q  <= in_div;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              hi_work_q <= '0;
              lo_work_q <= in_div ? a_mag : b_mag;
              opnd_q    <= in_div ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          hi_work_q <= hi_work_d;
          lo_work_q <= lo_work_d;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIN;
        end
        FIN: begin
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, hi_wdata, lo_wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch an op, scramble inputs after the accepting edge, wait for done.
  // lat counts negedges after the accepting edge; bcnt counts busy samples.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~av; b = ~bv;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  int  lat, bcnt;
  bit  seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dz",   64'(div_by_zero), 64'd0);
    chk("reset_hi",   64'(hi), 64'd0);
    chk("reset_lo",   64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULT -3 * 5 = -15
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
    chk("mult_latency", 64'(lat), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    chk("mult_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    chk("mult_done_pulse", 64'(done), 64'd0);

    // MULTU max * max
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    @(negedge clk);

    // DIV -7 / 2 -> q=-3, r=-1
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div_latency", 64'(lat), 64'd33);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIVU 100 / 7 -> q=14, r=2
    run_op(2'd3, 32'd100, 32'd7, lat, bcnt);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    // Divide by zero with preloaded HI/LO
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h1234; lo_wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("preload_hi", 64'(hi), 64'h1234);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("dz_e0_busy", 64'(busy), 64'd0);
    chk("dz_e0_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("dz_done", 64'(done), 64'd1);
    chk("dz_flag", 64'(div_by_zero), 64'd1);
    chk("dz_busy", 64'(busy), 64'd0);
    chk("dz_hi", 64'(hi), 64'h1234);
    chk("dz_lo", 64'(lo), 64'h1234);
    @(negedge clk);
    chk("dz_pulse_end", 64'({done, div_by_zero}), 64'd0);

    // DIV MIN / -1, with ignored second start and hi_we while busy
    start = 1'b1; op = 2'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_write_ignored", 64'(hi), 64'h1234);
    lat = 6;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ovf_latency", 64'(lat), 64'd33);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    chk("restart_ignored", 64'(seen), 64'd0);

    // Reset mid-MULT aborts with no result
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    lo_we = 1'b1; lo_wdata = 32'hA5;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hA5);
    chk("mtlo_hi", 64'(hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
